mux4a1_serial: RTL

Four-lane to one-lane serializing multiplexer: the transmit-side counterpart of the 1-to-4 byte demultiplexer. It accepts one 4-lane word (four bytes, each with its own valid) through a ready/valid handshake and emits it on a single 8-bit lane, one byte per clock, lane 0 first. It runs on one clock, which is the 4x word rate. A one-word holding buffer sustains back-to-back words with no idle slots.

---
 rtl/mux4a1_serial_if.sv | 22 ++
 rtl/mux4a1_serial.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux4a1_serial_if.sv
// Word-side handshake and serial-side outputs of the 4-lane to 1-lane serializer.
interface mux4a1_serial_if;
  logic [7:0] Entrada0, Entrada1, Entrada2, Entrada3;
  logic       validEntrada0, validEntrada1, validEntrada2, validEntrada3;
  logic       listo;
  logic [7:0] Salida;
  logic       validSalida;
  logic       inicio;
  logic [7:0] contPalabras;

  modport master (
    output Entrada0, Entrada1, Entrada2, Entrada3,
    output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    input  listo, Salida, validSalida, inicio, contPalabras
  );

  modport slave (
    input  Entrada0, Entrada1, Entrada2, Entrada3,
    input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    output listo, Salida, validSalida, inicio, contPalabras
  );
endinterface

// File: rtl/mux4a1_serial.sv
// Serializes one accepted 4-lane word onto an 8-bit lane, lane 0 first, one byte per clock,
// with a one-word holding buffer so consecutive words leave with no idle slot.
module mux4a1_serial (
  input logic             clk,
  input logic             reset,
  mux4a1_serial_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;

  logic [7:0] h_data [4];
  logic [3:0] h_valid;
  logic       lleno_h_q;
  logic [7:0] a_data [3];  // lanes 1..3 of the word on the lane
  logic [2:0] a_valid;

  logic [7:0] salida_q, salida_d;
  logic       valid_q, valid_d;
  logic       inicio_q, inicio_d;
  logic [7:0] cont_q;

  logic any_valid, accept, move;

  assign any_valid = bus.validEntrada0 | bus.validEntrada1 | bus.validEntrada2 |
                     bus.validEntrada3;
  assign bus.listo = !reset && !lleno_h_q;
  assign accept    = bus.listo && any_valid;
  // H can only be full or empty at an edge, so accept and move never coincide.
  assign move      = lleno_h_q && ((state_q == StIdle) || (slot_q == 2'd3));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      slot_q    <= 2'd0;
      salida_q  <= 8'h00;
      valid_q   <= 1'b0;
      inicio_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      salida_q  <= salida_d;
      valid_q   <= valid_d;
      inicio_q  <= inicio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) h_data[i] <= 8'h00;
      for (int i = 0; i < 3; i++) a_data[i] <= 8'h00;
      h_valid   <= 4'h0;
      a_valid   <= 3'h0;
      lleno_h_q <= 1'b0;
      cont_q    <= 8'h00;
    end else if (accept) begin
      h_data[0] <= bus.Entrada0;
      h_data[1] <= bus.Entrada1;
      h_data[2] <= bus.Entrada2;
      h_data[3] <= bus.Entrada3;
      h_valid   <= {bus.validEntrada3, bus.validEntrada2, bus.validEntrada1,
                    bus.validEntrada0};
      lleno_h_q <= 1'b1;
      cont_q    <= cont_q + 8'd1;
    end else if (move) begin
      a_data[0] <= h_data[1];
      a_data[1] <= h_data[2];
      a_data[2] <= h_data[3];
      a_valid   <= h_valid[3:1];
      lleno_h_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      StIdle: begin
        if (lleno_h_q) begin
          state_d = StSend;
          slot_d  = 2'd0;
        end
      end
      StSend: begin
        if (slot_q != 2'd3) begin
          slot_d = slot_q + 2'd1;
        end else if (lleno_h_q) begin
          slot_d = 2'd0;
        end else begin
          state_d = StIdle;
          slot_d  = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    salida_d = 8'h00;
    valid_d  = 1'b0;
    inicio_d = 1'b0;
    if (move) begin
      valid_d  = h_valid[0];
      salida_d = h_valid[0] ? h_data[0] : 8'h00;
      inicio_d = 1'b1;
    end else if (state_q == StSend) begin
      unique case (slot_q)
        2'd0: begin
          valid_d  = a_valid[0];
          salida_d = a_valid[0] ? a_data[0] : 8'h00;
        end
        2'd1: begin
          valid_d  = a_valid[1];
          salida_d = a_valid[1] ? a_data[1] : 8'h00;
        end
        2'd2: begin
          valid_d  = a_valid[2];
          salida_d = a_valid[2] ? a_data[2] : 8'h00;
        end
        default: ;  // slot 3 with empty H: lane goes idle
      endcase
    end
  end

  assign bus.Salida       = salida_q;
  assign bus.validSalida  = valid_q;
  assign bus.inicio       = inicio_q;
  assign bus.contPalabras = cont_q;

endmodule
